// File: rtl/d_debounce_pkg.sv
// Shared types, limits and parameter-legality helper for the D-input debouncer.
package d_debounce_pkg;

  typedef enum logic [1:0] {STABLE_LO, CHECK_HI, STABLE_HI, CHECK_LO} deb_state_t;

  localparam int MIN_SYNC_STAGES   = 2;
  localparam int MIN_STABLE_CYCLES = 1;

  // Evaluated at elaboration by the modules that import this package.
  function automatic bit deb_params_ok(input int sync_stages, input int stable_cycles,
                                       input int reset_level);
    return (sync_stages >= MIN_SYNC_STAGES) &&
           (stable_cycles >= MIN_STABLE_CYCLES) &&
           ((reset_level == 0) || (reset_level == 1));
  endfunction

endpackage

// File: rtl/d_input_debouncer_sync_chain.sv
// Plain N-flop synchroniser for a single asynchronous level; always shifting.
module sync_chain #(
  parameter int   STAGES      = 2,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] stage_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_q <= {STAGES{RESET_LEVEL}};
    end else begin
      stage_q <= {stage_q[STAGES-2:0], d};
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/d_input_debouncer.sv
// Synchronises a raw level and accepts a new value only after it has held
// for STABLE_CYCLES enabled edges; emits one-cycle rise/fall pulses.
module d_input_debouncer
  import d_debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 8,
  parameter int RESET_LEVEL   = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic din_async,
  input  logic enable,
  output logic d_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic busy
);

  localparam int               CNT_W     = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic             RST_LVL   = (RESET_LEVEL != 0);
  localparam deb_state_t       RST_STATE = RST_LVL ? STABLE_HI : STABLE_LO;

  if (!deb_params_ok(SYNC_STAGES, STABLE_CYCLES, RESET_LEVEL)) begin : g_param_check
    $error("d_input_debouncer: illegal SYNC_STAGES/STABLE_CYCLES/RESET_LEVEL");
  end

  logic             s;
  deb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dout_q, dout_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             busy_q, busy_d;

  sync_chain #(
    .STAGES      (SYNC_STAGES),
    .RESET_LEVEL (RST_LVL)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (din_async),
    .q     (s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
      dout_q  <= RST_LVL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  // The edge that leaves a STABLE state is the first qualifying sample.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (enable) begin
      case (state_q)
        STABLE_LO: begin
          if (s) begin
            if (STABLE_CYCLES == 1) begin
              state_d = STABLE_HI;
              dout_d  = 1'b1;
              rise_d  = 1'b1;
            end else begin
              state_d = CHECK_HI;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        CHECK_HI: begin
          if (!s) begin
            state_d = STABLE_LO;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = STABLE_HI;
            cnt_d   = '0;
            dout_d  = 1'b1;
            rise_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        STABLE_HI: begin
          if (!s) begin
            if (STABLE_CYCLES == 1) begin
              state_d = STABLE_LO;
              dout_d  = 1'b0;
              fall_d  = 1'b1;
            end else begin
              state_d = CHECK_LO;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        CHECK_LO: begin
          if (s) begin
            state_d = STABLE_HI;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = STABLE_LO;
            cnt_d   = '0;
            dout_d  = 1'b0;
            fall_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = RST_STATE;
          cnt_d   = '0;
        end
      endcase
    end
    busy_d = (state_d == CHECK_HI) || (state_d == CHECK_LO);
  end

  assign d_out      = dout_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_d_input_debouncer.sv
// Scoreboard bench: a run-length model predicts each cycle's outputs for a
// default build and a STABLE_CYCLES=1 / RESET_LEVEL=1 build.
module tb_d_input_debouncer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic din_async = 1'b0;
  logic enable = 1'b1;
  logic d_out0, rise0, fall0, busy0;
  logic d_out1, rise1, fall1, busy1;

  always #5 clk = ~clk;

  d_input_debouncer dut (
    .clk        (clk),
    .reset      (reset),
    .din_async  (din_async),
    .enable     (enable),
    .d_out      (d_out0),
    .rise_pulse (rise0),
    .fall_pulse (fall0),
    .busy       (busy0)
  );

  d_input_debouncer #(
    .SYNC_STAGES   (2),
    .STABLE_CYCLES (1),
    .RESET_LEVEL   (1)
  ) dut1 (
    .clk        (clk),
    .reset      (reset),
    .din_async  (din_async),
    .enable     (enable),
    .d_out      (d_out1),
    .rise_pulse (rise1),
    .fall_pulse (fall1),
    .busy       (busy1)
  );

  int err_cnt = 0;
  int chk_cnt = 0;
  int edge_cnt = 0;
  int rise_edge = -1;
  logic [7:0] sb_q [$];

  // Model state per build: sync pipe, accepted level, run of differing samples.
  logic [1:0] m_sync [2];
  logic       m_lvl  [2];
  int         m_run  [2];
  int         m_n    [2] = '{8, 1};
  logic       m_rl   [2] = '{1'b0, 1'b1};

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, act, exp, edge_cnt);
    end
  endtask

  task automatic model_step(input int k, input logic din_v, input logic en_v,
                            input logic rst_v, output logic [3:0] e);
    logic s;
    logic rise_e;
    logic fall_e;
    rise_e = 1'b0;
    fall_e = 1'b0;
    if (rst_v) begin
      m_sync[k] = {2{m_rl[k]}};
      m_lvl[k]  = m_rl[k];
      m_run[k]  = 0;
    end else begin
      s = m_sync[k][1];
      m_sync[k] = {m_sync[k][0], din_v};
      if (en_v) begin
        if (s != m_lvl[k]) begin
          m_run[k]++;
          if (m_run[k] >= m_n[k]) begin
            m_lvl[k] = s;
            m_run[k] = 0;
            rise_e   = s;
            fall_e   = !s;
          end
        end else begin
          m_run[k] = 0;
        end
      end
    end
    e = {m_lvl[k], rise_e, fall_e, (m_run[k] > 0)};
  endtask

  // Drives one cycle of stimulus and queues the outputs expected after the next edge.
  task automatic drive(input logic din_v, input logic en_v, input logic rst_v);
    logic [3:0] e0;
    logic [3:0] e1;
    @(posedge clk);
    #2;
    din_async = din_v;
    enable    = en_v;
    reset     = rst_v;
    model_step(0, din_v, en_v, rst_v, e0);
    model_step(1, din_v, en_v, rst_v, e1);
    sb_q.push_back({e0, e1});
    if (rst_v) begin
      #1;
      check_eq("async_rst_b0", {d_out0, rise0, fall0, busy0}, e0);
      check_eq("async_rst_b1", {d_out1, rise1, fall1, busy1}, e1);
    end
  endtask

  task automatic drive_n(input int n, input logic din_v, input logic en_v);
    for (int i = 0; i < n; i++) drive(din_v, en_v, 1'b0);
  endtask

  initial begin : monitor
    logic [7:0] exp;
    forever begin
      @(posedge clk);
      #1;
      edge_cnt++;
      if (sb_q.size() > 0) begin
        exp = sb_q.pop_front();
        check_eq("b0_d_out", d_out0, exp[7]);
        check_eq("b0_rise",  rise0,  exp[6]);
        check_eq("b0_fall",  fall0,  exp[5]);
        check_eq("b0_busy",  busy0,  exp[4]);
        check_eq("b1_d_out", d_out1, exp[3]);
        check_eq("b1_rise",  rise1,  exp[2]);
        check_eq("b1_fall",  fall1,  exp[1]);
        check_eq("b1_busy",  busy1,  exp[0]);
      end
      if (rise0 === 1'b1 && rise_edge < 0) rise_edge = edge_cnt;
    end
  end

  initial begin : stimulus
    int cap;
    int len;
    logic v;
    logic en_r;

    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b1);
    drive_n(4, 1'b0, 1'b1);

    // Clean rise with explicit latency measurement from the capture edge.
    rise_edge = -1;
    drive(1'b1, 1'b1, 1'b0);
    cap = edge_cnt + 1;
    drive_n(19, 1'b1, 1'b1);
    check_eq("rise_latency", rise_edge - cap + 1, 10);

    drive_n(20, 1'b0, 1'b1);

    // Seven qualifying samples are rejected, eight are accepted.
    drive_n(7, 1'b1, 1'b1);
    drive_n(12, 1'b0, 1'b1);
    drive_n(8, 1'b1, 1'b1);
    drive_n(14, 1'b0, 1'b1);

    // Freeze mid-qualification, then resume from the held count.
    drive_n(6, 1'b1, 1'b1);
    drive_n(5, 1'b1, 1'b0);
    drive_n(10, 1'b1, 1'b1);
    drive_n(14, 1'b0, 1'b1);

    // Reset while counting in CHECK_HI.
    drive_n(7, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b1);
    drive_n(14, 1'b1, 1'b1);

    // Randomised runs with sporadic enable drops.
    for (int r = 0; r < 12; r++) begin
      v   = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 12));
      for (int i = 0; i < len; i++) begin
        en_r = ($urandom_range(0, 5) != 0);
        drive(v, en_r, 1'b0);
      end
    end

    @(posedge clk);
    #2;
    check_eq("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
